serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder, downstream consumer of the halfadder stage.
//  Loads two operands on a start strobe, then adds one bit per clock, LSB first.
//  It uses a 1-bit full-adder datapath built from two halfadders and a carry flip-flop.
//  Result is a registered sum plus carry-out with a one-cycle done pulse; serves lab datapaths needing multi-bit add.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      request: load a/b and begin add (sampled only when accepting)
//  a      in   WIDTH  operand A, sampled on accepted start
//  b      in   WIDTH  operand B, sampled on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: sum/cout valid
//  sum    out  WIDTH  result, held stable until next accepted start
//  cout   out  1      carry-out of MSB, held with sum
// BEHAVIOUR
//  Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit count=0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> latch a,b into shift regs, carry=0, cnt=0 -> RUN.
//   RUN: each cycle compute s=a0^b0^carry and c=maj(a0,b0,carry);
//        shift s into sum MSB (sum shifts right), shift a/b right, carry<=c, cnt++.
//        After the WIDTH-th bit cycle (cnt==WIDTH-1), cout<=c -> DONE. start ignored.
//   DONE: done=1 for exactly this cycle; busy=0.
//        start=1 here is accepted exactly as in IDLE (-> RUN); otherwise -> IDLE.
//  Latency: start accepted at edge N, done high in cycle N+WIDTH+1. A new start may be accepted
//   on the done cycle, so the back-to-back throughput is one result per WIDTH+1 cycles.
//  sum/cout update only during RUN/at RUN->DONE; while RUN they hold partial data (not valid).
//  Overflow: result is modulo 2^WIDTH; overflow shows only in cout. No signed handling.
//  a/b changes after start acceptance have no effect (operands captured).
//  Reset mid-RUN: abort immediately, no done pulse, outputs return to reset values.
//  busy = (state==RUN); done = (state==DONE); both decoded from registered state (glitch-free).
// STRUCTURE
//  serial_adder_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
//   constant SA_DEFAULT_WIDTH = 8.
//  Counter width = $clog2(WIDTH), computed locally.
//  Sub-module full_adder_bit (a,b,cin -> s,cout): two halfadder instances plus an OR of their carries.
//   This is the only sub-module; the FSM and shift registers stay in serial_adder.
// TESTING (WIDTH=8)
//  1. rst pulse, then idle 3 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
//  2. start with a=0x05,b=0x03 -> busy high 8 cycles, done pulse on cycle 9, sum=0x08, cout=0.
//  3. a=0xFF,b=0x01 -> sum=0x00, cout=1; then a=0xFF,b=0xFF -> sum=0xFE, cout=1.
//  4. start re-asserted with a=0x11,b=0x11 mid-RUN of 0x0A+0x14 -> ignored, result sum=0x1E, cout=0.
//  5. rst asserted at bit 4 of 0xAA+0x55 -> outputs zero same edge, no done; next add 0x01+0x02=0x03.
//  6. start held high continuously -> done pulses every 9 cycles, each sum correct, no lost operand.
//  Bench self-checks against a+b on every done and asserts done is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   sa_state_t       : control FSM encoding (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Request/result bundle between a requester and the bit-serial adder.
//   start : request, load a/b and begin an add
//   a, b  : operands, sampled when start is accepted
//   busy  : high while the add is in progress
//   done  : one-cycle pulse, sum/cout valid
//   sum   : WIDTH-bit result, held until the next accepted start
//   cout  : carry-out of the MSB, held with sum
//   modport master : requester side; modport slave : adder side
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder_bit.sv
// halfadder
//   One-bit half adder: a_i, b_i -> s_o (xor), c_o (and).
// full_adder_bit
//   One-bit full adder built from two half adders; the two half-adder
//   carries can never both be 1, so an OR combines them.
//   a_i, b_i, cin_i : addend bits and carry-in
//   s_o, cout_o     : sum bit and carry-out
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : halfadder

module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  halfadder u_ha1 (
    .a_i (s1),
    .b_i (cin_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign cout_o = c1 | c2;

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. An accepted start captures a/b, then one
//   bit is added per clock LSB first through a single full_adder_bit and a
//   carry flip-flop. After WIDTH bit cycles, sum/cout are valid and done
//   pulses for one cycle. A new start is accepted in IDLE or DONE.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_adder_if.slave (start, a, b in; busy, done, sum, cout out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      // DONE accepts a start exactly like IDLE, giving WIDTH+1 cycle throughput
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum fills from the MSB, so after WIDTH shifts bit 0 sits at bit 0
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // done must never be high on two consecutive sampled cycles
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) chk("done_not_2x", 32'(bus.done & prev_done), 32'd0);
    prev_done = bus.done & ~rst;
  end

  // Wait (bounded) for done; n counts sampled cycles after acceptance
  task automatic wait_done(input string tag, output int n, output int busy_n);
    n = 1;
    busy_n = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd9);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec);
    int n, bn;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    // operands already captured; scrambling inputs must not matter
    bus.a = ~av;
    bus.b = ~bv;
    wait_done(tag, n, bn);
    chk({tag, "_busy_n"}, 32'(bn), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout_hold"}, 32'(bus.cout), 32'(ec));
  endtask

  logic [7:0] sa [4] = '{8'h12, 8'h80, 8'h7F, 8'hC3};
  logic [7:0] sb [4] = '{8'h34, 8'h80, 8'h01, 8'h3C};
  logic [7:0] ss [4] = '{8'h46, 8'h00, 8'h80, 8'hFF};
  logic       sc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int n, bn, dn;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;

    // 1. reset and idle
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_sum", 32'(bus.sum), 32'd0);
      chk("idle_cout", 32'(bus.cout), 32'd0);
    end

    // 2, 3. basic adds, wraparound and carry-out
    do_add("add_05_03", 8'h05, 8'h03, 8'h08, 1'b0);
    do_add("add_FF_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_add("add_FF_FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // 4. start re-asserted mid-RUN is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h0A;
    bus.b = 8'h14;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h11;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    n = 5;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_lat", 32'(n), 32'd9);
    chk("midrun_sum", 32'(bus.sum), 32'h1E);
    chk("midrun_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    chk("midrun_idle", 32'(bus.busy), 32'd0);

    // 5. reset mid-RUN aborts with no done pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    do_add("add_01_02", 8'h01, 8'h02, 8'h03, 1'b0);

    // 6. start held high: back-to-back results every 9 cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = sa[0];
    bus.b = sb[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.a = sa[k+1];
        bus.b = sb[k+1];
      end else begin
        bus.start = 1'b0;
      end
      wait_done($sformatf("b2b%0d", k), n, bn);
      chk($sformatf("b2b%0d_sum", k), 32'(bus.sum), 32'(ss[k]));
      chk($sformatf("b2b%0d_cout", k), 32'(bus.cout), 32'(sc[k]));
    end
    @(negedge clk);
    chk("b2b_end_idle", 32'(bus.busy | bus.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_adder
